// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//
// Register stage directly in front of the simple integer ALU. It takes a decoded
// instruction and resolves its Ra/Rb operands. Each operand comes from R31 (zero),
// the 8-bit literal (Rb only), an EX/WB forward, or the register-file read. The
// stage then presents the registered operands and function fields to the ALU
// behind a valid/ready handshake.
//
// A load in EX whose destination feeds the decoding instruction is a load-use
// hazard. In that case the stage emits a bubble and counts the stall cycle.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   flush_i              drop the held instruction, refuse new input this cycle
//   dec_*                decoded instruction offered by decode (valid/ready)
//   rf_ra/rb_data_i      same-cycle register-file reads of dec_ra_i / dec_rb_i
//   ex_fwd_*, wb_fwd_*   forwarding sources from EX and WB
//   ex_valid_o/ready_i   handshake towards the ALU
//   rs1_o, rs2_o         resolved operands
//   opcode_o, op_func_o, mem_func_o, rc_o   registered instruction fields
//   stall_cnt_o          saturating count of load-use stall cycles
module alu_operand_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             dec_valid_i,
  output logic             dec_ready_o,
  input  logic [5:0]       dec_opcode_i,
  input  logic [6:0]       dec_op_func_i,
  input  logic [15:0]      dec_mem_func_i,
  input  logic [4:0]       dec_ra_i,
  input  logic [4:0]       dec_rb_i,
  input  logic [4:0]       dec_rc_i,
  input  logic             dec_use_lit_i,
  input  logic [7:0]       dec_lit_i,
  input  logic [XLEN-1:0]  rf_ra_data_i,
  input  logic [XLEN-1:0]  rf_rb_data_i,
  input  logic             ex_fwd_valid_i,
  input  logic [4:0]       ex_fwd_rc_i,
  input  logic             ex_fwd_is_load_i,
  input  logic [XLEN-1:0]  ex_fwd_data_i,
  input  logic             wb_fwd_valid_i,
  input  logic [4:0]       wb_fwd_rc_i,
  input  logic [XLEN-1:0]  wb_fwd_data_i,
  output logic             ex_valid_o,
  input  logic             ex_ready_i,
  output logic [XLEN-1:0]  rs1_o,
  output logic [XLEN-1:0]  rs2_o,
  output logic [5:0]       opcode_o,
  output logic [6:0]       op_func_o,
  output logic [15:0]      mem_func_o,
  output logic [4:0]       rc_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [4:0] RegZero = 5'd31;

  logic             valid_q;
  logic [XLEN-1:0]  rs1_q, rs2_q;
  logic [5:0]       opcode_q;
  logic [6:0]       op_func_q;
  logic [15:0]      mem_func_q;
  logic [4:0]       rc_q;
  logic [CNT_W-1:0] stall_q;

  logic            load_en;
  logic            hazard;
  logic            ex_hit_a, wb_hit_a, ex_hit_b, wb_hit_b;
  logic [XLEN-1:0] ra_val, rb_val;

  // The output register can take new data when it is empty or is being drained.
  assign load_en = !valid_q || ex_ready_i;

  // A load in EX cannot forward yet. R31 is never a real destination. A literal
  // instruction does not read Rb, so Rb cannot cause a hazard in that case.
  assign hazard = dec_valid_i && ex_fwd_valid_i && ex_fwd_is_load_i &&
                  (ex_fwd_rc_i != RegZero) &&
                  ((ex_fwd_rc_i == dec_ra_i) ||
                   (!dec_use_lit_i && (ex_fwd_rc_i == dec_rb_i)));

  assign dec_ready_o = load_en && !hazard && !flush_i;

  // R31 is checked first in each chain, so a forward naming r31 can never win.
  assign ex_hit_a = ex_fwd_valid_i && !ex_fwd_is_load_i && (ex_fwd_rc_i == dec_ra_i);
  assign wb_hit_a = wb_fwd_valid_i && (wb_fwd_rc_i == dec_ra_i);
  assign ex_hit_b = ex_fwd_valid_i && !ex_fwd_is_load_i && (ex_fwd_rc_i == dec_rb_i);
  assign wb_hit_b = wb_fwd_valid_i && (wb_fwd_rc_i == dec_rb_i);

  always_comb begin
    ra_val = rf_ra_data_i;
    if (dec_ra_i == RegZero) begin
      ra_val = '0;
    end else if (ex_hit_a) begin
      ra_val = ex_fwd_data_i;
    end else if (wb_hit_a) begin
      ra_val = wb_fwd_data_i;
    end
  end

  always_comb begin
    rb_val = rf_rb_data_i;
    if (dec_use_lit_i) begin
      rb_val = {{(XLEN-8){1'b0}}, dec_lit_i};
    end else if (dec_rb_i == RegZero) begin
      rb_val = '0;
    end else if (ex_hit_b) begin
      rb_val = ex_fwd_data_i;
    end else if (wb_hit_b) begin
      rb_val = wb_fwd_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      opcode_q   <= '0;
      op_func_q  <= '0;
      mem_func_q <= '0;
      rc_q       <= '0;
      stall_q    <= '0;
    end else if (flush_i) begin
      // Payload is left stale; only the valid bit matters after a flush.
      valid_q <= 1'b0;
    end else if (load_en) begin
      if (hazard) begin
        valid_q <= 1'b0;
        if (stall_q != {CNT_W{1'b1}}) begin
          stall_q <= stall_q + CNT_W'(1);
        end
      end else if (dec_valid_i) begin
        valid_q    <= 1'b1;
        rs1_q      <= ra_val;
        rs2_q      <= rb_val;
        opcode_q   <= dec_opcode_i;
        op_func_q  <= dec_op_func_i;
        mem_func_q <= dec_mem_func_i;
        rc_q       <= dec_rc_i;
      end else begin
        valid_q <= 1'b0;
      end
    end
    // !load_en: the held instruction and its operands stay frozen.
  end

  assign ex_valid_o  = valid_q;
  assign rs1_o       = rs1_q;
  assign rs2_o       = rs2_q;
  assign opcode_o    = opcode_q;
  assign op_func_o   = op_func_q;
  assign mem_func_o  = mem_func_q;
  assign rc_o        = rc_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 32;
  localparam int NVEC = 13;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic             dec_valid_i;
  logic             dec_ready_o;
  logic [5:0]       dec_opcode_i;
  logic [6:0]       dec_op_func_i;
  logic [15:0]      dec_mem_func_i;
  logic [4:0]       dec_ra_i, dec_rb_i, dec_rc_i;
  logic             dec_use_lit_i;
  logic [7:0]       dec_lit_i;
  logic [XLEN-1:0]  rf_ra_data_i, rf_rb_data_i;
  logic             ex_fwd_valid_i;
  logic [4:0]       ex_fwd_rc_i;
  logic             ex_fwd_is_load_i;
  logic [XLEN-1:0]  ex_fwd_data_i;
  logic             wb_fwd_valid_i;
  logic [4:0]       wb_fwd_rc_i;
  logic [XLEN-1:0]  wb_fwd_data_i;
  logic             ex_valid_o;
  logic             ex_ready_i;
  logic [XLEN-1:0]  rs1_o, rs2_o;
  logic [5:0]       opcode_o;
  logic [6:0]       op_func_o;
  logic [15:0]      mem_func_o;
  logic [4:0]       rc_o;
  logic [CNT_W-1:0] stall_cnt_o;

  alu_operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_opcode_i(dec_opcode_i), .dec_op_func_i(dec_op_func_i),
    .dec_mem_func_i(dec_mem_func_i), .dec_ra_i(dec_ra_i), .dec_rb_i(dec_rb_i),
    .dec_rc_i(dec_rc_i), .dec_use_lit_i(dec_use_lit_i), .dec_lit_i(dec_lit_i),
    .rf_ra_data_i(rf_ra_data_i), .rf_rb_data_i(rf_rb_data_i),
    .ex_fwd_valid_i(ex_fwd_valid_i), .ex_fwd_rc_i(ex_fwd_rc_i),
    .ex_fwd_is_load_i(ex_fwd_is_load_i), .ex_fwd_data_i(ex_fwd_data_i),
    .wb_fwd_valid_i(wb_fwd_valid_i), .wb_fwd_rc_i(wb_fwd_rc_i),
    .wb_fwd_data_i(wb_fwd_data_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .opcode_o(opcode_o), .op_func_o(op_func_o),
    .mem_func_o(mem_func_o), .rc_o(rc_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [4:0]  ra, rb;
    logic        use_lit;
    logic [7:0]  lit;
    logic [63:0] rf_a, rf_b;
    logic        ex_v;
    logic [4:0]  ex_rc;
    logic        ex_load;
    logic [63:0] ex_data;
    logic        wb_v;
    logic [4:0]  wb_rc;
    logic [63:0] wb_data;
    logic        ex_rdy;
    logic        flush;
    // expected
    logic        e_ready;
    logic        e_valid;
    logic        chk_ops;
    logic [63:0] e_rs1, e_rs2;
    logic [31:0] e_stall;
  } vec_t;

  vec_t vecs[NVEC];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t base();
    vec_t v;
    v.dv = 1'b1; v.ra = 5'd3; v.rb = 5'd4; v.use_lit = 1'b0; v.lit = 8'h00;
    v.rf_a = 64'h11; v.rf_b = 64'h22;
    v.ex_v = 1'b0; v.ex_rc = 5'd0; v.ex_load = 1'b0; v.ex_data = 64'h0;
    v.wb_v = 1'b0; v.wb_rc = 5'd0; v.wb_data = 64'h0;
    v.ex_rdy = 1'b1; v.flush = 1'b0;
    v.e_ready = 1'b1; v.e_valid = 1'b1; v.chk_ops = 1'b1;
    v.e_rs1 = 64'h11; v.e_rs2 = 64'h22; v.e_stall = 32'd0;
    return v;
  endfunction

  task automatic drive(input vec_t v, input int idx);
    dec_valid_i = v.dv; dec_ra_i = v.ra; dec_rb_i = v.rb;
    dec_use_lit_i = v.use_lit; dec_lit_i = v.lit;
    rf_ra_data_i = v.rf_a; rf_rb_data_i = v.rf_b;
    ex_fwd_valid_i = v.ex_v; ex_fwd_rc_i = v.ex_rc; ex_fwd_is_load_i = v.ex_load;
    ex_fwd_data_i = v.ex_data;
    wb_fwd_valid_i = v.wb_v; wb_fwd_rc_i = v.wb_rc; wb_fwd_data_i = v.wb_data;
    ex_ready_i = v.ex_rdy; flush_i = v.flush;
    dec_opcode_i = 6'(idx + 1);
    dec_op_func_i = 7'(idx * 3 + 1);
    dec_mem_func_i = 16'(idx * 257 + 5);
    dec_rc_i = 5'(idx + 2);
  endtask

  initial begin
    vec_t v;
    // 0,1: back-to-back regfile operands
    vecs[0] = base();
    vecs[1] = base();
    // 2: EX beats WB beats regfile
    v = base(); v.ra = 5'd5; v.rf_a = 64'hCCCC;
    v.ex_v = 1; v.ex_rc = 5'd5; v.ex_data = 64'hAAAA;
    v.wb_v = 1; v.wb_rc = 5'd5; v.wb_data = 64'hBBBB; v.e_rs1 = 64'hAAAA;
    vecs[2] = v;
    // 3: EX dropped, WB wins
    v.ex_v = 0; v.e_rs1 = 64'hBBBB; vecs[3] = v;
    // 4: r31 reads zero even with forwards naming r31
    v = base(); v.ra = 5'd31; v.rf_a = 64'hCCCC;
    v.ex_v = 1; v.ex_rc = 5'd31; v.ex_data = 64'hAAAA;
    v.wb_v = 1; v.wb_rc = 5'd31; v.wb_data = 64'hBBBB; v.e_rs1 = 64'h0;
    vecs[4] = v;
    // 5: WB forward onto operand B
    v = base(); v.rb = 5'd9; v.rf_b = 64'h1; v.wb_v = 1; v.wb_rc = 5'd9;
    v.wb_data = 64'h99; v.e_rs2 = 64'h99; vecs[5] = v;
    // 6: load-use on Ra -> bubble
    v = base(); v.ra = 5'd7; v.ex_v = 1; v.ex_rc = 5'd7; v.ex_load = 1;
    v.ex_data = 64'hDEAD; v.e_ready = 0; v.e_valid = 0; v.chk_ops = 0; v.e_stall = 1;
    vecs[6] = v;
    // 7: load retired to WB, forwarded
    v = base(); v.ra = 5'd7; v.wb_v = 1; v.wb_rc = 5'd7; v.wb_data = 64'h55;
    v.e_rs1 = 64'h55; v.e_stall = 1; vecs[7] = v;
    // 8: literal bypasses Rb hazard
    v = base(); v.use_lit = 1; v.lit = 8'hFF; v.rb = 5'd7;
    v.ex_v = 1; v.ex_rc = 5'd7; v.ex_load = 1; v.e_rs2 = 64'hFF; v.e_stall = 1;
    vecs[8] = v;
    // 9: load-use on Rb
    v = base(); v.rb = 5'd8; v.ex_v = 1; v.ex_rc = 5'd8; v.ex_load = 1;
    v.e_ready = 0; v.e_valid = 0; v.chk_ops = 0; v.e_stall = 2; vecs[9] = v;
    // 10: load to r31 is not a hazard
    v = base(); v.ra = 5'd31; v.rb = 5'd31; v.ex_v = 1; v.ex_rc = 5'd31; v.ex_load = 1;
    v.e_rs1 = 64'h0; v.e_rs2 = 64'h0; v.e_stall = 2; vecs[10] = v;
    // 11: flush with hazard: flush wins, no count
    v = base(); v.ra = 5'd7; v.ex_v = 1; v.ex_rc = 5'd7; v.ex_load = 1; v.flush = 1;
    v.e_ready = 0; v.e_valid = 0; v.chk_ops = 0; v.e_stall = 2; vecs[11] = v;
    // 12: idle decode
    v = base(); v.dv = 0; v.e_valid = 0; v.chk_ops = 0; v.e_stall = 2; vecs[12] = v;

    rst = 1'b1;
    drive(base(), 0);
    dec_valid_i = 1'b0;
    @(negedge clk);
    chk("reset_valid", 64'(ex_valid_o), 64'h0);
    chk("reset_rs1", rs1_o, 64'h0);
    chk("reset_rs2", rs2_o, 64'h0);
    chk("reset_fields", {opcode_o, op_func_o, mem_func_o, rc_o}, 64'h0);
    chk("reset_stall", 64'(stall_cnt_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i], i);
      #1;
      chk($sformatf("v%0d_dec_ready", i), 64'(dec_ready_o), 64'(vecs[i].e_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ex_valid", i), 64'(ex_valid_o), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d_stall", i), 64'(stall_cnt_o), 64'(vecs[i].e_stall));
      if (vecs[i].chk_ops) begin
        chk($sformatf("v%0d_rs1", i), rs1_o, vecs[i].e_rs1);
        chk($sformatf("v%0d_rs2", i), rs2_o, vecs[i].e_rs2);
        chk($sformatf("v%0d_fields", i), {opcode_o, op_func_o, mem_func_o, rc_o},
            64'({6'(i + 1), 7'(i * 3 + 1), 16'(i * 257 + 5), 5'(i + 2)}));
      end
      @(negedge clk);
    end

    // Backpressure: capture one, then hold with ex_ready low and a hazard present.
    drive(base(), 20);
    @(posedge clk); #1;
    chk("bp_capture_valid", 64'(ex_valid_o), 64'h1);
    @(negedge clk);
    v = base(); v.ex_rdy = 0; v.ra = 5'd7; v.rf_a = 64'h77; v.rf_b = 64'h88;
    v.ex_v = 1; v.ex_rc = 5'd7; v.ex_load = 1;
    for (int c = 0; c < 3; c++) begin
      drive(v, 21 + c);
      #1;
      chk($sformatf("bp%0d_dec_ready", c), 64'(dec_ready_o), 64'h0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", c), 64'(ex_valid_o), 64'h1);
      chk($sformatf("bp%0d_rs1", c), rs1_o, 64'h11);
      chk($sformatf("bp%0d_rs2", c), rs2_o, 64'h22);
      chk($sformatf("bp%0d_opcode", c), 64'(opcode_o), 64'd21);
      chk($sformatf("bp%0d_stall", c), 64'(stall_cnt_o), 64'd2);
      @(negedge clk);
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    chk("flush_valid", 64'(ex_valid_o), 64'h0);
    chk("flush_stall", 64'(stall_cnt_o), 64'd2);
    @(negedge clk);

    // Asynchronous reset while holding a valid instruction.
    drive(base(), 30);
    @(posedge clk); #1;
    chk("pre_rst_valid", 64'(ex_valid_o), 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(ex_valid_o), 64'h0);
    chk("async_rst_rs1", rs1_o, 64'h0);
    chk("async_rst_fields", {opcode_o, op_func_o, mem_func_o, rc_o}, 64'h0);
    chk("async_rst_stall", 64'(stall_cnt_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    v = base(); v.rf_a = 64'h1234;
    drive(v, 31);
    #1;
    chk("post_rst_not_yet_valid", 64'(ex_valid_o), 64'h0);
    @(posedge clk); #1;
    chk("post_rst_valid", 64'(ex_valid_o), 64'h1);
    chk("post_rst_rs1", rs1_o, 64'h1234);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
